instr_encoder: RTL and testbench
================================

# instr_encoder

Packs instruction fields (format, opcode, registers, immediate, jump target) into 16-bit instruction words for the CPU's instruction memory. It is the encoding counterpart of the opcode classifier, and applies the same opcode-to-format map in reverse. Requests that name a format not matching the opcode are dropped and counted. Legal words are buffered in a 4-entry FIFO and streamed out with an auto-incrementing, reloadable memory address, so a loader can fill program memory one word per handshake.

## Interface
- AW, default 8, width of the instruction-memory address counter.
- DEPTH, default 4, FIFO depth. Power of two, ≥2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_fmt  in  2  requested format: 00 R, 01 I, 10 J, 11 illegal.
- in_opcode  in  4  opcode.
- in_rd, in_rs, in_rt  in  4 each  register fields.
- in_imm  in  8  I-type immediate.
- in_target  in  12  J-type target.
- base_load  in  1  load base_addr into the address counter.
- base_addr  in  AW  new address.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word.
- out_data  out  16  encoded word (FIFO head).
- out_addr  out  AW  memory address for out_data.
- err  out  1  one-cycle pulse on a rejected request.
- err_cnt  out  8  saturating count of rejected requests.

## Operation
- Opcode classes (fixed):
  - R = {0,2,4,5,6,11,13}
  - I = {1,3,7,8,9,10,12,14}
  - J = {15}
- A request is legal when in_fmt names the class of in_opcode. in_fmt=11 is always illegal.
- Encoding:
  - R: {opcode, rd, rs, rt}.
  - I: {opcode, rd, imm[7:0]}. in_rs and in_rt are ignored.
  - J: {opcode, target[11:0]}.
- Accept occurs when in_valid && in_ready.
  - Legal request: the word is pushed into the FIFO.
  - Illegal request: nothing is pushed. err pulses for one cycle, and err_cnt increments, saturating at 255.
- in_ready = !full. It does not depend on out_ready, so there is no pass-through when full.
- Pop occurs when out_valid && out_ready. On a pop, the address counter increments by 1, wrapping from 2^AW−1 to 0.
- If base_load and a pop occur in the same cycle, base_load wins and the counter takes base_addr with no increment.
- Push and pop in the same cycle leave the occupancy unchanged.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked in a counter of width log2(DEPTH)+1.
- Reset values: FIFO empty, in_ready=1, out_valid=0, out_data=0, out_addr=0, err=0, err_cnt=0.
  - Reset asserted mid-stream discards all buffered words with no further output.
  - Requests presented while rst=0 are not accepted.

## Timing
- Latency from an accepted legal request to out_valid is 1 cycle when the FIFO is empty: the word is registered at the FIFO tail and is visible at the head on the next cycle.
- out_data and out_addr are stable while out_valid=1 and out_ready=0.
- err is asserted in the cycle after the illegal accept. err_cnt updates in that same cycle.
- in_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- base_load updates out_addr on the next cycle and does not affect FIFO contents.
- Sustained throughput is one word per cycle when out_ready is held at 1.

## Test plan
- Reset, then a single R request (fmt=00, op=0, rd=1, rs=2, rt=3) → next cycle out_valid=1, out_data=0x0123, out_addr=0. After the pop, out_addr=1.
- I request (fmt=01, op=3, rd=4, imm=0xA5) and J request (fmt=10, op=15, target=0x0FF) → out_data=0x34A5, then 0xF0FF, at consecutive addresses.
- Mismatch (fmt=00, op=1) and fmt=11 requests → no output word, two err pulses, err_cnt=2. Hold 300 illegal requests → err_cnt saturates at 255.
- out_ready=0 with 5 legal requests → first 4 accepted, in_ready=0 from the cycle after the 4th. Release out_ready → words drain in order at addresses 0..3, then the 5th is accepted.
- base_load with base_addr=0xFE while streaming → addresses 0xFE, 0xFF, 0x00 (wrap). base_load coinciding with a pop → out_addr=base_addr, not base_addr+1.
- Assert rst with 3 words buffered → out_valid=0, out_addr=0, err_cnt=0 on the next cycle, and no stale word appears after rst is released.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs instruction fields into 16-bit instruction words and streams them
//   out through a small FIFO with an auto-incrementing memory address.
//   Requests whose format does not match the opcode class are dropped,
//   signalled on err and counted in a saturating err_cnt.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-low reset
//   in_valid   request valid          in_ready  FIFO not full
//   in_fmt     00 R, 01 I, 10 J, 11 illegal
//   in_opcode, in_rd, in_rs, in_rt, in_imm, in_target   instruction fields
//   base_load  load base_addr into the address counter (wins over a pop)
//   out_valid / out_ready / out_data / out_addr   word stream with address
//   err        one-cycle pulse after a rejected request
//   err_cnt    saturating count of rejected requests
module instr_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_fmt,
    input  logic [3:0]    in_opcode,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rs,
    input  logic [3:0]    in_rt,
    input  logic [7:0]    in_imm,
    input  logic [11:0]   in_target,
    input  logic          base_load,
    input  logic [AW-1:0] base_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_BAD = 2'b11
    } fmt_t;

    fmt_t          op_class;
    logic          legal;
    logic [15:0]   word;
    logic          accept;
    logic          push;
    logic          pop;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] addr;

    // Fixed opcode-to-format map shared with the opcode classifier.
    always_comb begin
        op_class = FMT_I;
        case (in_opcode)
            4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd11, 4'd13: op_class = FMT_R;
            4'd15:                                      op_class = FMT_J;
            default:                                    op_class = FMT_I;
        endcase
    end

    // op_class is never FMT_BAD, so fmt=11 can never be legal.
    assign legal = (fmt_t'(in_fmt) == op_class);

    always_comb begin
        word = '0;
        case (op_class)
            FMT_R:   word = {in_opcode, in_rd, in_rs, in_rt};
            FMT_I:   word = {in_opcode, in_rd, in_imm};
            default: word = {in_opcode, in_target};
        endcase
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_addr  = addr;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            addr    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (base_load) begin
                addr <= base_addr;
            end else if (pop) begin
                addr <= addr + AW'(1);
            end

            err <= accept && !legal;
            if (accept && !legal && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_fmt;
    logic [3:0]    in_opcode;
    logic [3:0]    in_rd;
    logic [3:0]    in_rs;
    logic [3:0]    in_rt;
    logic [7:0]    in_imm;
    logic [11:0]   in_target;
    logic          base_load;
    logic [AW-1:0] base_addr;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [7:0]    err_cnt;

    int vectors = 0;
    int miscompares = 0;

    instr_encoder #(.AW(AW), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .base_load (base_load),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_q[$];
    int  m_addr;
    int  m_err;
    int  m_cnt;
    bit  m_ok = 0;

    function automatic int class_of(input int op);
        int r_ops[7] = '{0, 2, 4, 5, 6, 11, 13};
        if (op == 15) return 2;
        foreach (r_ops[k]) if (r_ops[k] == op) return 0;
        return 1;
    endfunction

    function automatic int encode(input int fmt, input int op);
        if (fmt == 0) return op * 4096 + in_rd * 256 + in_rs * 16 + in_rt;
        if (fmt == 1) return op * 4096 + in_rd * 256 + in_imm;
        return op * 4096 + in_target;
    endfunction

    // Checks outputs at the falling edge, then advances the model using the
    // inputs that the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
                chk("in_ready", int'(in_ready), int'(m_q.size() < 4));
                chk("out_addr", int'(out_addr), m_addr);
                chk("err", int'(err), m_err);
                chk("err_cnt", int'(err_cnt), m_cnt);
                if (m_q.size() != 0) chk("out_data", int'(out_data), m_q[0]);
            end
            if (rst !== 1'b1) begin
                m_q.delete();
                m_addr = 0;
                m_err  = 0;
                m_cnt  = 0;
                m_ok   = 1;
            end else if (m_ok) begin
                bit acc, pop;
                int fmt, op, w;
                acc = in_valid && (m_q.size() < 4);
                pop = (m_q.size() != 0) && out_ready;
                fmt = int'(in_fmt);
                op  = int'(in_opcode);
                w   = encode(fmt, op);
                if (pop) void'(m_q.pop_front());
                if (base_load) m_addr = int'(base_addr);
                else if (pop) m_addr = (m_addr + 1) % (1 << AW);
                m_err = 0;
                if (acc) begin
                    if (fmt != 3 && fmt == class_of(op)) m_q.push_back(w);
                    else begin
                        m_err = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic req(input int fmt, input int op, input int rd, input int rs,
                       input int rt, input int imm, input int tgt);
        in_valid  = 1'b1;
        in_fmt    = 2'(fmt);
        in_opcode = 4'(op);
        in_rd     = 4'(rd);
        in_rs     = 4'(rs);
        in_rt     = 4'(rt);
        in_imm    = 8'(imm);
        in_target = 12'(tgt);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_fmt = '0; in_opcode = '0;
        in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0; in_target = '0;
        base_load = 1'b0; base_addr = '0; out_ready = 1'b0;
        tick(2);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_data", int'(out_data), 0);
        chk("rst out_addr", int'(out_addr), 0);
        chk("rst err_cnt", int'(err_cnt), 0);
        rst = 1'b1;

        // single R request
        req(0, 0, 1, 2, 3, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("R valid", int'(out_valid), 1);
        chk("R data", int'(out_data), 'h0123);
        chk("R addr", int'(out_addr), 0);
        out_ready = 1'b1;
        tick();
        chk("R addr after pop", int'(out_addr), 1);

        // I then J back to back
        req(1, 3, 4, 9, 9, 'hA5, 0);
        tick();
        chk("I data", int'(out_data), 'h34A5);
        chk("I addr", int'(out_addr), 1);
        req(2, 15, 0, 0, 0, 0, 'h0FF);
        tick();
        in_valid = 1'b0;
        chk("J data", int'(out_data), 'hF0FF);
        chk("J addr", int'(out_addr), 2);
        tick();

        // illegal requests
        req(0, 1, 1, 1, 1, 0, 0);
        tick();
        chk("mismatch err", int'(err), 1);
        chk("mismatch cnt", int'(err_cnt), 1);
        chk("mismatch no word", int'(out_valid), 0);
        req(3, 0, 0, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("fmt11 cnt", int'(err_cnt), 2);
        tick();
        chk("err cleared", int'(err), 0);
        req(2, 0, 0, 0, 0, 0, 0);
        tick(300);
        in_valid = 1'b0;
        chk("err_cnt sat", int'(err_cnt), 255);
        tick();

        // fill with out_ready low
        base_load = 1'b1; base_addr = '0;
        tick();
        base_load = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(0, 2, i, 0, 0, 0, 0);
            tick();
        end
        chk("full in_ready", int'(in_ready), 0);
        req(0, 2, 4, 0, 0, 0, 0);
        tick();
        chk("fifth held", int'(in_ready), 0);
        out_ready = 1'b1;
        chk("drain head", int'(out_data), 'h2000);
        chk("drain addr0", int'(out_addr), 0);
        tick();
        chk("drain addr1", int'(out_addr), 1);
        chk("drain data1", int'(out_data), 'h2100);
        chk("ready back", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        tick(6);

        // address wrap while streaming
        base_load = 1'b1; base_addr = 8'hFE;
        tick();
        base_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(2, 15, 0, 0, 0, 0, 'h100 + i);
            tick();
            chk("wrap addr", int'(out_addr), (254 + i) % 256);
        end
        in_valid = 1'b0;
        tick();

        // base_load coinciding with a pop
        out_ready = 1'b0;
        req(1, 7, 5, 0, 0, 'h3C, 0);
        tick();
        in_valid = 1'b0;
        base_load = 1'b1; base_addr = 8'h40; out_ready = 1'b1;
        tick();
        base_load = 1'b0;
        chk("load beats pop", int'(out_addr), 'h40);

        // reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(0, 4, i, 1, 1, 0, 0);
            tick();
        end
        in_valid = 1'b0;
        req(1, 1, 1, 0, 0, 0, 0);
        req(3, 1, 1, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst out_addr", int'(out_addr), 0);
        chk("midrst err_cnt", int'(err_cnt), 0);
        chk("midrst err", int'(err), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        tick(3);
        chk("no stale word", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
